// File: rtl/axil_app_arbiter.sv
// Round-robin arbiter sharing the single app-side port of axis_lite_m between NUM_REQ requesters.
// One transaction in flight at a time; all outputs come straight from registers.
//
//   state | meaning
//   IDLE  | no transaction in flight, searching for the next grant
//   ISSUE | start strobe and accept pulse to the granted requester
//   WAIT  | waiting for the matching done pulse from the master
//   RESP  | completion pulse to the granted requester
module axil_app_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         app_waddr,
    output logic [DATA_W-1:0]         app_wdata,
    output logic                      app_wen,
    input  logic                      app_wdone,
    output logic [ADDR_W-1:0]         app_raddr,
    output logic                      app_ren,
    input  logic [DATA_W-1:0]         app_rdata,
    input  logic                      app_rdone
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_q;
    logic             wr_q;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic             done_match;
    logic             take_grant;
    logic             take_done;

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_idx   = PTR_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign done_match = wr_q ? app_wdone : app_rdone;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_match) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign take_grant = (state_q == IDLE) && grant_found;
    assign take_done  = (state_q == WAIT) && done_match;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_q     <= '0;
            wr_q      <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            app_waddr <= '0;
            app_wdata <= '0;
            app_raddr <= '0;
            app_wen   <= 1'b0;
            app_ren   <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            app_wen   <= 1'b0;
            app_ren   <= 1'b0;

            if (take_grant) begin
                gnt_q                <= grant_idx;
                wr_q                 <= req_write[grant_idx];
                req_ready[grant_idx] <= 1'b1;
                if (req_write[grant_idx]) begin
                    app_wen   <= 1'b1;
                    app_waddr <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    app_wdata <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                end else begin
                    app_ren   <= 1'b1;
                    app_raddr <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                end
            end

            if (take_done) begin
                rsp_valid[gnt_q] <= 1'b1;
                rsp_rdata        <= wr_q ? '0 : app_rdata;
            end

            // Pointer moves past the served requester only once its response is out.
            if (state_q == RESP) begin
                rr_ptr <= (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_app_arbiter.sv
// Directed + randomized bench for axil_app_arbiter; expected grants come from a
// round-robin reference model over a table of pending requests.
module tb_axil_app_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] app_waddr;
    logic [DW-1:0] app_wdata;
    logic          app_wen;
    logic          app_wdone;
    logic [AW-1:0] app_raddr;
    logic          app_ren;
    logic [DW-1:0] app_rdata;
    logic          app_rdone;

    axil_app_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .app_waddr (app_waddr),
        .app_wdata (app_wdata),
        .app_wen   (app_wen),
        .app_wdone (app_wdone),
        .app_raddr (app_raddr),
        .app_ren   (app_ren),
        .app_rdata (app_rdata),
        .app_rdone (app_rdone)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending request table and round-robin pointer.
    bit          pv[N];
    bit          pw[N];
    logic [31:0] pa[N];
    logic [31:0] pd[N];
    int          mptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pv[i];
            req_write[i]           = pw[i];
            req_addr[i*AW +: AW]   = pa[i];
            req_wdata[i*DW +: DW]  = pd[i];
        end
    endtask

    task automatic new_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        pv[i] = 1'b1;
        pw[i] = w;
        pa[i] = a;
        pd[i] = d;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (pv[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_rspv"},  32'(rsp_valid), 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_waddr"}, app_waddr, 0);
        chk({tag, "_wdata"}, app_wdata, 0);
        chk({tag, "_raddr"}, app_raddr, 0);
        chk({tag, "_strb"},  {30'b0, app_wen, app_ren}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge aclk);
        reset = 1'b0;
        mptr  = 0;
        @(negedge aclk);
    endtask

    // Waits for the ISSUE cycle and checks grant, strobe and bus values against the model.
    task automatic wait_issue(output int eg);
        int waited;
        eg     = model_grant();
        waited = 0;
        do begin
            @(negedge aclk);
            waited++;
        end while (!(app_wen || app_ren) && waited < 20);
        chk("issue_strobe", {31'b0, app_wen | app_ren}, 1);
        if (eg < 0 || !(app_wen || app_ren)) begin
            eg = -1;
            return;
        end
        chk("grant_ready", 32'(req_ready), 32'(1) << eg);
        chk("issue_wen", {31'b0, app_wen}, {31'b0, pw[eg]});
        chk("issue_ren", {31'b0, app_ren}, {31'b0, ~pw[eg]});
        if (pw[eg]) begin
            chk("issue_waddr", app_waddr, pa[eg]);
            chk("issue_wdata", app_wdata, pd[eg]);
        end else begin
            chk("issue_raddr", app_raddr, pa[eg]);
        end
    endtask

    // keep: 0 drop after accept, 1 re-request, 2 random choice.
    task automatic run_txn(input int lat, input int keep, input bit spur,
                           input logic [31:0] rd, output int g);
        bit w;
        bit k;
        wait_issue(g);
        if (g < 0) return;
        w = pw[g];
        k = (keep == 1) || (keep == 2 && ($urandom % 2 == 1));
        if (k) new_req(g, $urandom % 2 == 1, $urandom, $urandom);
        else   pv[g] = 1'b0;
        drive_reqs();
        for (int i = 0; i < lat; i++) begin
            @(negedge aclk);
            if (i == 0) begin
                chk("wait_ready", 32'(req_ready), 0);
                chk("wait_strb", {30'b0, app_wen, app_ren}, 0);
            end
            chk("wait_no_rsp", 32'(rsp_valid), 0);
            if (spur && i == 0) begin
                if (w) app_rdone = 1'b1;
                else   app_wdone = 1'b1;
            end else begin
                app_wdone = 1'b0;
                app_rdone = 1'b0;
            end
            app_rdata = $urandom;
        end
        app_rdata = rd;
        if (w) app_wdone = 1'b1;
        else   app_rdone = 1'b1;
        @(negedge aclk);
        app_wdone = 1'b0;
        app_rdone = 1'b0;
        app_rdata = $urandom;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << g);
        chk("rsp_rdata", rsp_rdata, w ? 32'h0 : rd);
        mptr = (g + 1) % N;
        @(negedge aclk);
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
        chk("rdata_hold", rsp_rdata, w ? 32'h0 : rd);
    endtask

    initial begin
        int g;
        int order[$];
        reset = 1'b1;
        app_wdone = 1'b0;
        app_rdone = 1'b0;
        app_rdata = '0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0;
        end
        drive_reqs();
        mptr = 0;
        repeat (3) @(negedge aclk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge aclk);

        // Spurious done pulses while idle.
        app_wdone = 1'b1;
        @(negedge aclk);
        app_wdone = 1'b0;
        app_rdone = 1'b1;
        @(negedge aclk);
        app_rdone = 1'b0;
        chk("idle_spur_rspv", 32'(rsp_valid), 0);
        @(negedge aclk);
        chk("idle_spur_rspv2", 32'(rsp_valid), 0);
        chk("idle_spur_strb", {30'b0, app_wen, app_ren}, 0);

        // Single write from requester 1.
        new_req(1, 1'b1, 32'hAAAABBBB, 32'h5AA5A55A);
        drive_reqs();
        run_txn(3, 0, 1'b0, 32'hDEADBEEF, g);
        chk("single_write_g", g, 1);

        // Single read from requester 0.
        new_req(0, 1'b0, 32'h00000010, 32'h0);
        drive_reqs();
        run_txn(2, 0, 1'b0, 32'h12345678, g);
        chk("single_read_g", g, 0);
        chk("single_read_raddr", app_raddr, 32'h10);

        // Simultaneous requests right after reset.
        do_reset();
        for (int i = 0; i < N; i++) new_req(i, i % 2 == 1, $urandom, $urandom);
        drive_reqs();
        for (int i = 0; i < N; i++) begin
            run_txn(1 + i, 0, 1'b0, $urandom, g);
            chk("simul_order", g, i);
        end
        new_req(0, 1'b0, $urandom, $urandom);
        new_req(2, 1'b1, $urandom, $urandom);
        drive_reqs();
        run_txn(2, 0, 1'b0, $urandom, g);
        chk("pair_first", g, 0);
        run_txn(2, 0, 1'b0, $urandom, g);
        chk("pair_second", g, 2);

        // Fairness: 0 and 3 hold valid continuously.
        do_reset();
        new_req(0, 1'b1, $urandom, $urandom);
        new_req(3, 1'b0, $urandom, $urandom);
        drive_reqs();
        order = '{0, 3, 0, 3, 0, 3};
        foreach (order[i]) begin
            run_txn(1 + (i % 3), (i >= 4) ? 0 : 1, 1'b0, $urandom, g);
            chk("fair_order", g, order[i]);
        end

        // Wrong-direction done during a read's WAIT.
        do_reset();
        new_req(1, 1'b0, 32'h00000044, 32'h0);
        drive_reqs();
        run_txn(4, 0, 1'b1, 32'hCAFEF00D, g);
        chk("spur_read_g", g, 1);

        // Reset in the middle of a requester 2 write.
        new_req(2, 1'b1, 32'h00002222, 32'h22220000);
        drive_reqs();
        wait_issue(g);
        chk("rst_mid_g", g, 2);
        pv[2] = 1'b0;
        drive_reqs();
        @(negedge aclk);
        @(negedge aclk);
        reset = 1'b1;
        #1;
        chk_outputs_zero("rst_mid");
        app_wdone = 1'b1;
        @(negedge aclk);
        app_wdone = 1'b0;
        @(negedge aclk);
        reset = 1'b0;
        mptr  = 0;
        chk("rst_mid_no_rsp", 32'(rsp_valid), 0);
        @(negedge aclk);
        chk("rst_mid_no_rsp2", 32'(rsp_valid), 0);
        new_req(3, 1'b1, $urandom, $urandom);
        new_req(0, 1'b0, $urandom, $urandom);
        drive_reqs();
        run_txn(2, 0, 1'b0, $urandom, g);
        chk("post_rst_first", g, 0);
        run_txn(2, 0, 1'b0, $urandom, g);
        chk("post_rst_second", g, 3);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            int lat;
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom % 3 == 0)) new_req(i, $urandom % 2 == 1, $urandom, $urandom);
                any |= pv[i];
            end
            if (!any) new_req($urandom % N, $urandom % 2 == 1, $urandom, $urandom);
            drive_reqs();
            lat = 1 + ($urandom % 5);
            run_txn(lat, 2, (lat >= 3) && ($urandom % 2 == 1), $urandom, g);
            if (g < 0) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
